mem_line_ctrl: RTL and testbench

- Line-transfer controller sitting directly upstream of the byte-wide main memory; the memory is driven only through mem_cs/mem_oe/mem_we/mem_addr and the shared 8-bit bidirectional mem_data bus.
- Accepts one cache-line refill (read) or writeback (write) request at a time from the cache over a valid/ready handshake.
- Sequences the line into LINE_BYTES single-byte memory accesses and returns the assembled line with a single-cycle response strobe.

---
 rtl/mem_line_ctrl_if.sv | 37 +++
 rtl/mem_line_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_mem_line_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_ctrl_if.sv
// Cache-side request/response bundle for mem_line_ctrl.
// The cache drives requests through the master modport; the controller
// accepts them and returns the assembled line through the slave modport.
interface mem_line_ctrl_if #(
    parameter int LINE_BYTES = 16
);
    // Request channel (valid/ready handshake)
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [31:0]               req_addr;
    logic [LINE_BYTES*8-1:0]   req_wdata;

    // Response channel (single-cycle strobe)
    logic                      resp_valid;
    logic [LINE_BYTES*8-1:0]   resp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_valid,
        output resp_rdata
    );
endinterface

// File: rtl/mem_line_ctrl.sv
// mem_line_ctrl: moves one cache line at a time between the cache and a
// byte-wide main memory. A refill (read) or writeback (write) is split into
// LINE_BYTES back-to-back byte beats, each held on the bus for MEM_LAT cycles.
//
// Timing: the request is accepted on an edge; the next cycle is a set-up
// cycle in which the first beat is computed into the bus registers, then the
// beats appear on the bus, then one DONE cycle with resp_valid=1. This gives
// 1 + LINE_BYTES*MEM_LAT cycles from accept edge to resp_valid.
// Every bus signal comes straight from a flop; the beat counters run one
// cycle ahead of what the bus shows, so a "drain" flag keeps the FSM in XFER
// for the cycle in which the final beat is still on the bus.
//
// Optional feature macro: MEMLINE_WRAP_FIRST_EN
//   defined   -> refills start at the requested byte and wrap inside the line
//   undefined -> every transfer runs ascending from offset 0
module mem_line_ctrl #(
    parameter int LINE_BYTES = 16,
    parameter int MEM_LAT    = 2
) (
    input  logic           clk,
    input  logic           reset,
    mem_line_ctrl_if.slave cache,
    output logic           mem_cs,
    output logic           mem_oe,
    output logic           mem_we,
    output logic [31:0]    mem_addr,
    inout  wire  [7:0]     mem_data
);

    localparam int OFFW = $clog2(LINE_BYTES);
    localparam int CNTW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int LW   = LINE_BYTES * 8;

    localparam logic [OFFW-1:0] IDX_LAST = OFFW'(LINE_BYTES - 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MEM_LAT - 1);
    localparam logic [31:0]     LOW_MASK = 32'(LINE_BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // FSM and beat sequencing
    state_t            state_q, state_d;
    logic [OFFW-1:0]   idx_q, idx_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              drain_q, drain_d;

    // Latched request
    logic [31:0]       base_q, base_d;
    logic              line_we_q, line_we_d;
    logic [LW-1:0]     wdata_q, wdata_d;
    logic [OFFW-1:0]   off_q, off_d;

    // Cache-side outputs and refill assembly buffer
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [LW-1:0]     resp_rdata_q, resp_rdata_d;
    logic [LW-1:0]     rbuf_q, rbuf_d;

    // Registered memory bus and the beat it currently shows
    logic              mem_cs_q, mem_cs_d;
    logic              mem_oe_q, mem_oe_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              drv_en_q, drv_en_d;
    logic [7:0]        drv_data_q, drv_data_d;
    logic              beat_last_q, beat_last_d;
    logic [OFFW-1:0]   bus_pos_q, bus_pos_d;

    logic [OFFW-1:0]   pos_s;
    logic              accept_s;

    // Byte position inside the line for beat number idx, wrapping at the line end
    function automatic logic [OFFW-1:0] line_pos(input logic [OFFW-1:0] start,
                                                 input logic [OFFW-1:0] idx);
        return start + idx;
    endfunction

    assign pos_s    = line_pos(off_q, idx_q);
    assign accept_s = cache.req_valid && req_ready_q;

    // Next-state, beat sequencing, bus control and refill assembly
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        base_d       = base_q;
        line_we_d    = line_we_q;
        wdata_d      = wdata_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_cs_d     = 1'b0;
        mem_oe_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        drv_en_d     = 1'b0;
        drv_data_d   = 8'h00;
        beat_last_d  = 1'b0;
        bus_pos_d    = bus_pos_q;

        // Capture the read byte on the edge that ends the last cycle of a read beat
        rbuf_d = rbuf_q;
        if (mem_oe_q && beat_last_q) begin
            rbuf_d[{bus_pos_q, 3'b000} +: 8] = mem_data;
        end else begin
            rbuf_d = rbuf_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d   = ST_XFER;
                    idx_d     = {OFFW{1'b0}};
                    cnt_d     = {CNTW{1'b0}};
                    drain_d   = 1'b0;
                    base_d    = cache.req_addr & ~LOW_MASK;
                    line_we_d = cache.req_we;
                    wdata_d   = cache.req_wdata;
`ifdef MEMLINE_WRAP_FIRST_EN
                    // Critical byte first applies to refills only
                    if (cache.req_we) begin
                        off_d = {OFFW{1'b0}};
                    end else begin
                        off_d = cache.req_addr[OFFW-1:0];
                    end
`else
                    off_d = {OFFW{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_XFER: begin
                if (!drain_q) begin
                    // Present the beat selected by the counters on the bus next cycle
                    mem_cs_d    = 1'b1;
                    mem_addr_d  = base_q | {{(32-OFFW){1'b0}}, pos_s};
                    bus_pos_d   = pos_s;
                    beat_last_d = (cnt_q == CNT_LAST);
                    if (line_we_q) begin
                        mem_we_d   = 1'b1;
                        drv_en_d   = 1'b1;
                        drv_data_d = wdata_q[{pos_s, 3'b000} +: 8];
                    end else begin
                        mem_oe_d   = 1'b1;
                    end

                    if (cnt_q == CNT_LAST) begin
                        cnt_d = {CNTW{1'b0}};
                        if (idx_q == IDX_LAST) begin
                            drain_d = 1'b1;
                        end else begin
                            idx_d = idx_q + OFFW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end else begin
                    // Final beat is on the bus this cycle; finish on its closing edge
                    state_d      = ST_DONE;
                    drain_d      = 1'b0;
                    resp_valid_d = 1'b1;
                    if (!line_we_q) begin
                        resp_rdata_d = rbuf_d;
                    end else begin
                        resp_rdata_d = resp_rdata_q;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= {OFFW{1'b0}};
            cnt_q        <= {CNTW{1'b0}};
            drain_q      <= 1'b0;
            base_q       <= 32'h0000_0000;
            line_we_q    <= 1'b0;
            wdata_q      <= {LW{1'b0}};
            off_q        <= {OFFW{1'b0}};
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {LW{1'b0}};
            rbuf_q       <= {LW{1'b0}};
            mem_cs_q     <= 1'b0;
            mem_oe_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'h0000_0000;
            drv_en_q     <= 1'b0;
            drv_data_q   <= 8'h00;
            beat_last_q  <= 1'b0;
            bus_pos_q    <= {OFFW{1'b0}};
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            base_q       <= base_d;
            line_we_q    <= line_we_d;
            wdata_q      <= wdata_d;
            off_q        <= off_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            rbuf_q       <= rbuf_d;
            mem_cs_q     <= mem_cs_d;
            mem_oe_q     <= mem_oe_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            drv_en_q     <= drv_en_d;
            drv_data_q   <= drv_data_d;
            beat_last_q  <= beat_last_d;
            bus_pos_q    <= bus_pos_d;
        end
    end

    assign cache.req_ready  = req_ready_q;
    assign cache.resp_valid = resp_valid_q;
    assign cache.resp_rdata = resp_rdata_q;

    assign mem_cs   = mem_cs_q;
    assign mem_oe   = mem_oe_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;

    // Data bus is driven only during write beats
    assign mem_data = drv_en_q ? drv_data_q : 8'hzz;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Scoreboard bench for mem_line_ctrl. The driver pushes the expected bus
// beats and the expected response into queues when a request is accepted;
// independent monitors pop and compare whenever the DUT shows bus activity
// or a response strobe. Expected values come from a byte-addressed memory
// model and the line-transfer rules, not from the controller's internals.
module tb_mem_line_ctrl;

    localparam int LB      = 16;
    localparam int LAT     = 2;
    localparam int LW      = LB * 8;
    localparam int LATENCY = 1 + LB * LAT;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_cs, mem_oe, mem_we;
    logic [31:0] mem_addr;
    wire  [7:0]  mem_data;

    always #5 clk = ~clk;

    mem_line_ctrl_if #(.LINE_BYTES(LB)) cif();

    mem_line_ctrl #(.LINE_BYTES(LB), .MEM_LAT(LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .cache    (cif),
        .mem_cs   (mem_cs),
        .mem_oe   (mem_oe),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- memory device on the bus ----------------
    logic [7:0] dev_mem [logic [31:0]];
    logic [7:0] dev_rd;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] dev_read(input logic [31:0] a);
        if (dev_mem.exists(a)) return dev_mem[a];
        return init_byte(a);
    endfunction

    always @(negedge clk) dev_rd = dev_read(mem_addr);
    always @(posedge clk) if (mem_cs && mem_we) dev_mem[mem_addr] = mem_data;
    assign mem_data = (mem_cs && mem_oe) ? dev_rd : 8'hzz;

    // ---------------- reference model and scoreboard ----------------
    typedef struct { logic [31:0] addr; logic wr; logic [7:0] data; } beat_t;
    typedef struct { logic wr; logic [LW-1:0] rdata; int acc; } resp_t;

    beat_t         exp_beats[$];
    resp_t         exp_resp[$];
    int            resp_hist[$];
    logic [7:0]    ref_mem [logic [31:0]];
    logic [LW-1:0] last_refill = '0;

    function automatic logic [7:0] ref_read(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    task automatic push_model(input logic we, input logic [31:0] addr,
                              input logic [LW-1:0] wdata, input int acc);
        logic [31:0]   base;
        int            off;
        int            pos;
        logic [LW-1:0] line;
        beat_t         b;
        resp_t         r;
        base = addr & ~32'(LB - 1);
        off  = 0;
`ifdef MEMLINE_WRAP_FIRST_EN
        if (!we) off = int'(addr % 32'(LB));
`endif
        line = last_refill;
        for (int k = 0; k < LB; k++) begin
            pos    = (off + k) % LB;
            b.addr = base + 32'(pos);
            b.wr   = we;
            b.data = we ? wdata[pos*8 +: 8] : 8'h00;
            for (int c = 0; c < LAT; c++) exp_beats.push_back(b);
            if (we) ref_mem[b.addr] = b.data;
            else    line[pos*8 +: 8] = ref_read(b.addr);
        end
        if (!we) last_refill = line;
        r.wr = we; r.rdata = last_refill; r.acc = acc;
        exp_resp.push_back(r);
    endtask

    // Bus and response monitor
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (!reset) begin
            if (mem_oe && mem_we) check("oe_we_both_high", LW'(1), LW'(0));
            if (mem_cs) begin
                if (exp_beats.size() == 0) begin
                    check("beat_unexpected", LW'(mem_addr), LW'(0));
                end else begin
                    b = exp_beats.pop_front();
                    check("beat_addr", LW'(mem_addr), LW'(b.addr));
                    check("beat_we", LW'(mem_we), LW'(b.wr));
                    check("beat_oe", LW'(mem_oe), LW'(!b.wr));
                    if (b.wr) check("beat_wdata", LW'(mem_data), LW'(b.data));
                end
            end else begin
                check("idle_ctrl", LW'({mem_oe, mem_we}), LW'(2'b00));
            end
            if (cif.resp_valid) begin
                resp_hist.push_back(cyc);
                if (exp_resp.size() == 0) begin
                    check("resp_unexpected", LW'(1), LW'(0));
                end else begin
                    r = exp_resp.pop_front();
                    check("resp_latency", LW'(cyc - r.acc), LW'(LATENCY));
                    check(r.wr ? "resp_rdata_wb" : "resp_rdata_refill", cif.resp_rdata, r.rdata);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic we, input logic [31:0] addr,
                         input logic [LW-1:0] wdata, input bit keep, output int acc);
        cif.req_valid = 1'b1;
        cif.req_we    = we;
        cif.req_addr  = addr;
        cif.req_wdata = wdata;
        acc = -1;
        for (int t = 0; t < 400; t++) begin
            if (cif.req_ready) begin
                acc = cyc + 1;
                push_model(we, addr, wdata, acc);
                @(negedge clk);
                if (!keep) cif.req_valid = 1'b0;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) begin
            check("accept_timeout", LW'(0), LW'(1));
            cif.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_resp.size() != 0 || !cif.req_ready) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("idle_timeout", LW'(exp_resp.size()), LW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] seq_line;
        logic [LW-1:0] rnd;
        logic [31:0]   lines [5];
        int            acc, acc1, acc2, h, found;

        lines[0] = 32'h0000_0100; lines[1] = 32'h0000_0200; lines[2] = 32'h0000_03A0;
        lines[3] = 32'hFFFF_FFF0; lines[4] = 32'h0000_04C0;
        for (int i = 0; i < LB; i++) seq_line[i*8 +: 8] = 8'h10 + 8'(i);

        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state held through five idle cycles
        for (int i = 0; i < 5; i++) begin
            check("rst_ready", LW'(cif.req_ready), LW'(1));
            check("rst_resp_valid", LW'(cif.resp_valid), LW'(0));
            check("rst_ctrl", LW'({mem_cs, mem_oe, mem_we}), LW'(3'b000));
            check("rst_addr", LW'(mem_addr), LW'(0));
            check("rst_rdata", cif.resp_rdata, LW'(0));
            @(negedge clk);
        end

        // Writeback of an ascending byte pattern, then refill of the same line
        issue(1'b1, 32'h0000_0100, seq_line, 1'b0, acc);
        check("busy_after_accept", LW'(cif.req_ready), LW'(0));
        wait_idle();
        check("wb_keeps_rdata", cif.resp_rdata, LW'(0));
        issue(1'b0, 32'h0000_0100, '0, 1'b0, acc);
        wait_idle();
        check("refill_const", cif.resp_rdata, seq_line);

        // Refill with low address bits set (order depends on the wrap feature)
        issue(1'b0, 32'h0000_0107, '0, 1'b0, acc);
        wait_idle();
        check("refill_low_bits", cif.resp_rdata, seq_line);

        // Top-of-address-space line must not carry out of the line
        rnd = {$urandom, $urandom, $urandom, $urandom};
        issue(1'b1, 32'hFFFF_FFF0, rnd, 1'b0, acc);
        wait_idle();
        issue(1'b0, 32'hFFFF_FFF5, '0, 1'b0, acc);
        wait_idle();
        check("refill_top_line", cif.resp_rdata, rnd);

        // Two queued requests with req_valid held high
        h = resp_hist.size();
        rnd = {$urandom, $urandom, $urandom, $urandom};
        issue(1'b1, 32'h0000_0200, rnd, 1'b1, acc1);
        issue(1'b0, 32'h0000_0200, '0, 1'b0, acc2);
        wait_idle();
        if (resp_hist.size() > h) check("queued_accept_gap", LW'(acc2), LW'(resp_hist[h] + 2));
        else check("queued_first_resp", LW'(resp_hist.size()), LW'(h + 1));
        check("queued_refill", cif.resp_rdata, rnd);

        // Reset during beat 5 of a writeback
        issue(1'b1, 32'h0000_9000, {$urandom, $urandom, $urandom, $urandom}, 1'b0, acc);
        found = 0;
        for (int t = 0; t < 100; t++) begin
            if (mem_cs && mem_addr == 32'h0000_9005) begin found = 1; break; end
            @(negedge clk);
        end
        check("abort_reach_beat5", LW'(found), LW'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_beats.delete();
        exp_resp.delete();
        last_refill = '0;
        check("abort_ready", LW'(cif.req_ready), LW'(1));
        check("abort_ctrl", LW'({mem_cs, mem_oe, mem_we}), LW'(3'b000));
        check("abort_resp_valid", LW'(cif.resp_valid), LW'(0));
        repeat (40) @(negedge clk);
        issue(1'b0, 32'h0000_010C, '0, 1'b0, acc);
        wait_idle();
        check("refill_after_abort", cif.resp_rdata, seq_line);

        // Randomized traffic over a few lines
        for (int n = 0; n < 12; n++) begin
            logic [31:0] a;
            a = lines[$urandom_range(0, 4)] | 32'($urandom_range(0, LB - 1));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            issue(1'($urandom_range(0, 1)), a, rnd, 1'b0, acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);
        check("beats_drained", LW'(exp_beats.size()), LW'(0));
        check("resps_drained", LW'(exp_resp.size()), LW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
